// File: rtl/aer_rx_timestamper_pkg.sv
// Shared definitions for the AER receive timestamper.
//   AER_DATA_W   : width of the word written into the input FIFO
//   AER_ADDR_LSB : bit position of the address field (address in the LSBs)
//   AER_TS_MSB   : top bit of the timestamp field (timestamp in the MSBs)
//   aer_state_e  : handshake FSM encoding
package aer_rx_timestamper_pkg;

    localparam int unsigned AER_DATA_W   = 24;
    localparam int unsigned AER_ADDR_LSB = 0;
    localparam int unsigned AER_TS_MSB   = AER_DATA_W - 1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWrite = 2'd1,
        StAck   = 2'd2
    } aer_state_e;

endpackage

// File: rtl/aer_rx_timestamper_if.sv
// Bundle of the AER sender handshake and the input-FIFO write port.
//   aer_req    : AER request, asynchronous to clk
//   aer_addr   : AER address, stable while aer_req is high
//   aer_ack    : AER acknowledge
//   fifo_full  : input FIFO full flag
//   fifo_wr_en : FIFO write strobe
//   fifo_din   : FIFO write data {ts, addr}
// Modport slave is the timestamper; modport master is its environment (the AER
// sender plus the FIFO).
interface aer_rx_timestamper_if
    import aer_rx_timestamper_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) ();

    logic                  aer_req;
    logic [ADDR_W-1:0]     aer_addr;
    logic                  aer_ack;
    logic                  fifo_full;
    logic                  fifo_wr_en;
    logic [AER_DATA_W-1:0] fifo_din;

    modport master (
        output aer_req,
        output aer_addr,
        output fifo_full,
        input  aer_ack,
        input  fifo_wr_en,
        input  fifo_din
    );

    modport slave (
        input  aer_req,
        input  aer_addr,
        input  fifo_full,
        output aer_ack,
        output fifo_wr_en,
        output fifo_din
    );

endinterface

// File: rtl/aer_rx_timestamper_sync.sv
// Multi-flop synchroniser for the asynchronous AER request.
//   clk     : destination clock
//   rst     : asynchronous active-high reset, clears the chain to 0
//   async_i : asynchronous input
//   sync_o  : input delayed by SYNC_STAGES flops
module aer_rx_timestamper_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o
);

    logic [SYNC_STAGES-1:0] chain_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], async_i};
        end
    end

    assign sync_o = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/aer_rx_timestamper.sv
// AER receive front end: synchronises a 4-phase bundled-data request, stamps
// each event with a free-running timestamp and writes {ts, addr} into the
// input FIFO, one word per handshake.
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   aer_bus  : AER req/ack/addr and FIFO full/wr_en/din (slave side)
//   drop_cnt : events discarded on a full FIFO, saturating
//   busy     : FSM is not idle
module aer_rx_timestamper
    import aer_rx_timestamper_pkg::*;
#(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned TS_W         = 16,
    parameter int unsigned TICK_DIV     = 100,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DROP_ON_FULL = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    aer_rx_timestamper_if.slave  aer_bus,
    output logic [15:0]          drop_cnt,
    output logic                 busy
);

    if (ADDR_W + TS_W != AER_DATA_W || TICK_DIV < 1 || SYNC_STAGES < 2) begin : g_param_chk
        $error("aer_rx_timestamper: illegal parameter combination");
    end

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    logic                  req_s;
    logic                  tick;
    logic [PRE_W-1:0]      pre_q, pre_d;
    logic [TS_W-1:0]       ts_q, ts_d;
    aer_state_e            state_q, state_d;
    logic [AER_DATA_W-1:0] ev_q, ev_d;
    logic                  ack_q, ack_d;
    logic [15:0]           drop_q, drop_d;
    logic                  wr_en;

    aer_rx_timestamper_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (aer_bus.aer_req),
        .sync_o  (req_s)
    );

    // Timestamp base: ts advances once per TICK_DIV clocks and wraps silently.
    assign tick  = (pre_q == PRE_MAX);
    assign pre_d = tick ? '0 : pre_q + 1'b1;
    assign ts_d  = tick ? ts_q + 1'b1 : ts_q;

    always_comb begin
        state_d = state_q;
        ev_d    = ev_q;
        ack_d   = ack_q;
        drop_d  = drop_q;
        wr_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                // ts_q is the pre-edge value, so a same-edge tick is not seen.
                if (req_s) begin
                    ev_d[AER_TS_MSB -: TS_W]     = ts_q;
                    ev_d[AER_ADDR_LSB +: ADDR_W] = aer_bus.aer_addr;
                    state_d                      = StWrite;
                end
            end
            StWrite: begin
                wr_en = !aer_bus.fifo_full;
                if (!aer_bus.fifo_full) begin
                    ack_d   = 1'b1;
                    state_d = StAck;
                end else if (DROP_ON_FULL != 0) begin
                    if (drop_q != 16'hFFFF) begin
                        drop_d = drop_q + 16'd1;
                    end
                    ack_d   = 1'b1;
                    state_d = StAck;
                end
            end
            StAck: begin
                // Wait for the return-to-zero phase; a held req cannot re-trigger.
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                ack_d   = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q   <= '0;
            ts_q    <= '0;
            state_q <= StIdle;
            ev_q    <= '0;
            ack_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            pre_q   <= pre_d;
            ts_q    <= ts_d;
            state_q <= state_d;
            ev_q    <= ev_d;
            ack_q   <= ack_d;
            drop_q  <= drop_d;
        end
    end

    assign aer_bus.aer_ack    = ack_q;
    assign aer_bus.fifo_wr_en = wr_en;
    assign aer_bus.fifo_din   = ev_q;
    assign drop_cnt           = drop_q;
    assign busy               = (state_q != StIdle);

endmodule

// File: tb/tb_aer_rx_timestamper.sv
// Directed bench for aer_rx_timestamper. Three instances share clk/rst:
//   dut_stall : TICK_DIV=4, stall on full
//   dut_drop  : TICK_DIV=4, drop on full
//   dut_wrap  : TICK_DIV=1, timestamp advances every clock
// cyc counts clock edges since the last reset release; with TICK_DIV=4 the
// timestamp after k edges is k/4, with TICK_DIV=1 it is k mod 2^16.
module tb_aer_rx_timestamper;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [15:0] s_drop, d_drop, w_drop;
    logic        s_busy, d_busy, w_busy;

    int unsigned cyc;
    int unsigned s_wr = 0;
    int unsigned d_wr = 0;
    int unsigned w_wr = 0;
    int unsigned n_pass = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    aer_rx_timestamper_if #(.ADDR_W(8)) s_if ();
    aer_rx_timestamper_if #(.ADDR_W(8)) d_if ();
    aer_rx_timestamper_if #(.ADDR_W(8)) w_if ();

    aer_rx_timestamper #(
        .ADDR_W(8), .TS_W(16), .TICK_DIV(4), .SYNC_STAGES(2), .DROP_ON_FULL(0)
    ) dut_stall (
        .clk(clk), .rst(rst), .aer_bus(s_if), .drop_cnt(s_drop), .busy(s_busy)
    );

    aer_rx_timestamper #(
        .ADDR_W(8), .TS_W(16), .TICK_DIV(4), .SYNC_STAGES(2), .DROP_ON_FULL(1)
    ) dut_drop (
        .clk(clk), .rst(rst), .aer_bus(d_if), .drop_cnt(d_drop), .busy(d_busy)
    );

    aer_rx_timestamper #(
        .ADDR_W(8), .TS_W(16), .TICK_DIV(1), .SYNC_STAGES(2), .DROP_ON_FULL(0)
    ) dut_wrap (
        .clk(clk), .rst(rst), .aer_bus(w_if), .drop_cnt(w_drop), .busy(w_busy)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(posedge clk) begin
        if (s_if.fifo_wr_en) s_wr <= s_wr + 1;
        if (d_if.fifo_wr_en) d_wr <= d_wr + 1;
        if (w_if.fifo_wr_en) w_wr <= w_wr + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic step_to(input int unsigned target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        s_if.aer_req = 1'b0; s_if.aer_addr = 8'h00; s_if.fifo_full = 1'b0;
        d_if.aer_req = 1'b0; d_if.aer_addr = 8'h00; d_if.fifo_full = 1'b0;
        w_if.aer_req = 1'b0; w_if.aer_addr = 8'h00; w_if.fifo_full = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack",  32'(s_if.aer_ack), 0);
        chk("rst_wr",   32'(s_if.fifo_wr_en), 0);
        chk("rst_din",  32'(s_if.fifo_din), 0);
        chk("rst_drop", 32'(d_drop), 0);
        chk("rst_busy", 32'(s_busy), 0);
        rst = 1'b0;

        // 1: single event, req rises after edge 10, captured at edge 13 (ts=3)
        step_to(10);
        s_if.aer_addr = 8'h5A;
        s_if.aer_req  = 1'b1;
        step(2);
        chk("t1_wr_early", 32'(s_if.fifo_wr_en), 0);
        chk("t1_busy_early", 32'(s_busy), 0);
        step(1);
        chk("t1_wr", 32'(s_if.fifo_wr_en), 1);
        chk("t1_din", 32'(s_if.fifo_din), 32'h00035A);
        chk("t1_ack_pre", 32'(s_if.aer_ack), 0);
        chk("t1_busy", 32'(s_busy), 1);
        step(1);
        chk("t1_ack", 32'(s_if.aer_ack), 1);
        chk("t1_wr_done", 32'(s_if.fifo_wr_en), 0);
        step(2);
        s_if.aer_req = 1'b0;
        step(2);
        chk("t1_ack_hold", 32'(s_if.aer_ack), 1);
        step(1);
        chk("t1_ack_fall", 32'(s_if.aer_ack), 0);
        chk("t1_idle", 32'(s_busy), 0);
        chk("t1_wr_cnt", s_wr, 1);

        // 2: stall on full for 10 WRITE cycles; capture at edge 33 (ts=8)
        s_if.fifo_full = 1'b1;
        step_to(30);
        s_if.aer_addr = 8'hA5;
        s_if.aer_req  = 1'b1;
        step(3);
        for (int i = 0; i < 10; i++) begin
            chk("t2_stall_wr", 32'(s_if.fifo_wr_en), 0);
            chk("t2_stall_ack", 32'(s_if.aer_ack), 0);
            if (i < 9) step(1);
        end
        step(1);
        chk("t2_stall_busy", 32'(s_busy), 1);
        s_if.fifo_full = 1'b0;
        #1;
        chk("t2_wr", 32'(s_if.fifo_wr_en), 1);
        chk("t2_din", 32'(s_if.fifo_din), 32'h0008A5);
        step(1);
        chk("t2_ack", 32'(s_if.aer_ack), 1);
        s_if.aer_req = 1'b0;
        step(3);
        chk("t2_ack_fall", 32'(s_if.aer_ack), 0);
        chk("t2_wr_cnt", s_wr, 2);

        // 4: req held 50 cycles after ack, then a second event
        step_to(60);
        s_if.aer_addr = 8'h3C;
        s_if.aer_req  = 1'b1;
        step(4);
        chk("t4_ack", 32'(s_if.aer_ack), 1);
        chk("t4_wr_cnt1", s_wr, 3);
        step(50);
        chk("t4_hold_ack", 32'(s_if.aer_ack), 1);
        chk("t4_hold_wr_cnt", s_wr, 3);
        s_if.aer_req = 1'b0;
        step(3);
        chk("t4_ack_fall", 32'(s_if.aer_ack), 0);
        step(1);
        s_if.aer_addr = 8'hC3;
        s_if.aer_req  = 1'b1;
        step(3);
        chk("t4_wr2", 32'(s_if.fifo_wr_en), 1);
        chk("t4_din2", 32'(s_if.fifo_din), 32'h001EC3);
        step(1);
        s_if.aer_req = 1'b0;
        step(3);
        chk("t4_ack_fall2", 32'(s_if.aer_ack), 0);
        chk("t4_wr_cnt2", s_wr, 4);

        // 3: drop-on-full, three events acked without a write
        d_if.fifo_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            d_if.aer_addr = 8'(8'h10 + k);
            d_if.aer_req  = 1'b1;
            step(3);
            chk("t3_busy", 32'(d_busy), 1);
            chk("t3_wr", 32'(d_if.fifo_wr_en), 0);
            step(1);
            chk("t3_ack", 32'(d_if.aer_ack), 1);
            d_if.aer_req = 1'b0;
            step(3);
            chk("t3_ack_fall", 32'(d_if.aer_ack), 0);
        end
        chk("t3_drop_cnt", 32'(d_drop), 3);
        chk("t3_wr_cnt", d_wr, 0);
        force dut_drop.drop_q = 16'hFFFF;
        step(1);
        release dut_drop.drop_q;
        chk("t3_preload", 32'(d_drop), 32'hFFFF);
        d_if.aer_req = 1'b1;
        step(4);
        chk("t3_sat_ack", 32'(d_if.aer_ack), 1);
        chk("t3_sat_cnt", 32'(d_drop), 32'hFFFF);
        d_if.aer_req = 1'b0;
        step(3);
        d_if.fifo_full = 1'b0;

        // 6: reset in WRITE, then in ACK; held req is recaptured each time
        s_if.fifo_full = 1'b1;
        s_if.aer_addr  = 8'h77;
        s_if.aer_req   = 1'b1;
        step(3);
        chk("t6_in_write", 32'(s_busy), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6w_ack", 32'(s_if.aer_ack), 0);
        chk("t6w_wr", 32'(s_if.fifo_wr_en), 0);
        chk("t6w_din", 32'(s_if.fifo_din), 0);
        chk("t6w_busy", 32'(s_busy), 0);
        chk("t6w_drop", 32'(d_drop), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        s_if.fifo_full = 1'b0;
        step(3);
        chk("t6w_recap_wr", 32'(s_if.fifo_wr_en), 1);
        chk("t6w_recap_din", 32'(s_if.fifo_din), 32'h000077);
        step(1);
        chk("t6a_in_ack", 32'(s_if.aer_ack), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6a_ack", 32'(s_if.aer_ack), 0);
        chk("t6a_busy", 32'(s_busy), 0);
        chk("t6a_din", 32'(s_if.fifo_din), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(3);
        chk("t6a_recap_wr", 32'(s_if.fifo_wr_en), 1);
        chk("t6a_recap_din", 32'(s_if.fifo_din), 32'h000077);
        step(1);
        s_if.aer_req = 1'b0;
        step(3);
        chk("t6_ack_fall", 32'(s_if.aer_ack), 0);
        chk("t6_wr_cnt", s_wr, 6);

        // 5: timestamp wrap; capture edge 65537 stores ts after 65536 edges = 0
        step_to(65534);
        chk("t5_no_wr_before", w_wr, 0);
        w_if.aer_addr = 8'hE1;
        w_if.aer_req  = 1'b1;
        step(2);
        chk("t5_wr_early", 32'(w_if.fifo_wr_en), 0);
        step(1);
        chk("t5_wr", 32'(w_if.fifo_wr_en), 1);
        chk("t5_din", 32'(w_if.fifo_din), 32'h0000E1);
        step(1);
        chk("t5_wr_done", 32'(w_if.fifo_wr_en), 0);
        chk("t5_ack", 32'(w_if.aer_ack), 1);
        w_if.aer_req = 1'b0;
        step(3);
        chk("t5_ack_fall", 32'(w_if.aer_ack), 0);
        chk("t5_wr_cnt", w_wr, 1);

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule
